// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and the forwarding logic that
// mirrors its write priority.
package regfile_pkg;

    localparam int unsigned ADDR_W_MAX   = 16;
    localparam int unsigned DATA_W_MAX   = 64;
    localparam int unsigned ZERO_REG_IDX = 0;

    typedef logic [ADDR_W_MAX-1:0] wrAddr_t;
    typedef logic [DATA_W_MAX-1:0] wrData_t;

    typedef struct packed {
        logic    en;
        wrAddr_t addr;
        wrData_t data;
    } wrPort_t;

    function automatic int unsigned addrWidth(int unsigned numRegs);
        return (numRegs < 2) ? 1 : $clog2(numRegs);
    endfunction

    // Port A carries the younger instruction, so on an address collision port B is dropped.
    function automatic wrPort_t prioritizeB(wrPort_t a, wrPort_t b);
        wrPort_t r;
        r = b;
        if (a.en && b.en && (a.addr == b.addr)) begin
            r.en = 1'b0;
        end
        return r;
    endfunction

    function automatic logic portHits(wrPort_t p, wrAddr_t addr);
        return p.en && (p.addr == addr);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding long-latency results, an incrementally maintained
// busy count, and the busy lookup for each read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issEn,
    input  logic [AW-1:0]      issAddr,
    input  logic               wrAEn,
    input  logic [AW-1:0]      wrAAddr,
    input  logic               wrBEn,
    input  logic [AW-1:0]      wrBAddr,
    input  logic [NUM_RD*AW-1:0] rdAddr,
    output logic [NUM_RD-1:0]  rdBusy,
    output logic [AW:0]        busyCount
);

    localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] busyQ, busyD;
    logic [AW:0]         countQ, countD;
    logic [AW:0]         incCnt, decCnt;

    always_comb begin
        busyD  = busyQ;
        incCnt = '0;
        decCnt = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if ((wrAEn && (wrAAddr == AW'(r))) || (wrBEn && (wrBAddr == AW'(r)))) begin
                busyD[r] = 1'b0;
            end
            // Issue is applied after the clears so a same-cycle issue leaves the bit set.
            if (issEn && (issAddr == AW'(r)) && !((ZERO_REG != 0) && (r == ZERO_REG_IDX))) begin
                busyD[r] = 1'b1;
            end
            if (busyD[r] && !busyQ[r]) begin
                incCnt = incCnt + CntOne;
            end
            if (!busyD[r] && busyQ[r]) begin
                decCnt = decCnt + CntOne;
            end
        end
        countD = countQ + incCnt - decCnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busyQ  <= '0;
            countQ <= '0;
        end else begin
            busyQ  <= busyD;
            countQ <= countD;
        end
    end

    assign busyCount = countQ;

    for (genvar i = 0; i < NUM_RD; i++) begin : gBusy
        logic [AW-1:0] addr;
        assign addr = rdAddr[i*AW +: AW];
        // A same-cycle write bypasses the data, so the register is no longer pending.
        assign rdBusy[i] = busyQ[addr] && !(wrAEn && (wrAAddr == addr))
                                       && !(wrBEn && (wrBAddr == addr));
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read register file with an ALU (A) and a long-latency (B) write port, same-cycle
// write-to-read bypass and a busy scoreboard for RAW stall detection.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = addrWidth(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [AW-1:0]            wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [AW:0]              busy_count
);

    logic [DATA_W-1:0] regsQ [NUM_REGS];
    wrPort_t           wrA, wrB, wrBEff;
    logic [AW-1:0]     waIdx, wbIdx;
    logic              unusedWrBits;

    function automatic logic isZeroReg(logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(ZERO_REG_IDX));
    endfunction

    assign wrA    = '{en: wa_en, addr: wrAddr_t'(wa_addr), data: wrData_t'(wa_data)};
    assign wrB    = '{en: wb_en, addr: wrAddr_t'(wb_addr), data: wrData_t'(wb_data)};
    assign wrBEff = prioritizeB(wrA, wrB);
    assign waIdx  = wrA.addr[AW-1:0];
    assign wbIdx  = wrBEff.addr[AW-1:0];

    // Ports are carried at the package's maximum width; the upper bits are zero padding.
    assign unusedWrBits = ^{wrA, wrB, wrBEff};

    // wrBEff never collides with wrA, so the two writes are independent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regsQ[r] <= '0;
            end
        end else begin
            if (wrA.en && !isZeroReg(waIdx)) begin
                regsQ[waIdx] <= wrA.data[DATA_W-1:0];
            end
            if (wrBEff.en && !isZeroReg(wbIdx)) begin
                regsQ[wbIdx] <= wrBEff.data[DATA_W-1:0];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = regsQ[addr];
            if (portHits(wrB, wrAddr_t'(addr))) begin
                data = wrB.data[DATA_W-1:0];
            end
            if (portHits(wrA, wrAddr_t'(addr))) begin
                data = wrA.data[DATA_W-1:0];
            end
            if (isZeroReg(addr)) begin
                data = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) uScoreboard (
        .clock     (clock),
        .reset     (reset),
        .issEn     (iss_en),
        .issAddr   (iss_addr),
        .wrAEn     (wa_en),
        .wrAAddr   (wa_addr),
        .wrBEn     (wb_en),
        .wrBAddr   (wb_addr),
        .rdAddr    (rd_addr),
        .rdBusy    (rd_busy),
        .busyCount (busy_count)
    );

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with two write ports, same-cycle write-to-read bypass and a per-register busy scoreboard. It is the next-generation replacement for the single-write, two-read MIPS register file. It sits in the decode stage: read ports feed operand fetch, port A takes ALU writeback, port B takes long-latency (load/multiply) writeback. The scoreboard tracks registers with an outstanding long-latency result, so issue logic can stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, ≥2); AW = clog2(NUM_REGS)
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issues

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy flag of each read address
- wa_en  in  1  write port A enable (ALU writeback)
- wa_addr  in  AW  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B enable (long-latency writeback)
- wb_addr  in  AW  write port B address
- wb_data  in  DATA_W  write port B data
- iss_en  in  1  mark iss_addr busy (long-latency op issued)
- iss_addr  in  AW  destination being marked busy
- busy_count  out  AW+1  number of registers currently busy

## Operation
- Reads are combinational, with this priority per port:
  - addr 0 with ZERO_REG=1 → 0
  - else wa_en && wa_addr==addr → wa_data
  - else wb_en && wb_addr==addr → wb_data
  - else the array value
- Writes commit on the rising edge. If wa_addr==wb_addr with both enabled, port A wins (younger instruction) and the port B data is dropped. Writes to register 0 are ignored when ZERO_REG=1.
- Scoreboard holds one busy bit per register.
  - Set on an edge with iss_en; ignored for register 0 when ZERO_REG=1.
  - Cleared on an edge by any enabled write (A or B) to that register.
  - Issue and write to the same address in the same cycle → bit ends set (issue wins).
  - Issue to an already-busy register → stays set; no count change.
- rd_busy[i] = busy[rd_addr[i]], masked to 0 when a same-cycle write (A or B) targets that address. This keeps it consistent with the bypassed data.
- busy_count equals the popcount of the busy bits after every edge. It is maintained incrementally as +1 (set of a clear bit), −1 for each cleared bit (up to 2 when A and B clear different bits), or a net combination of these. It never exceeds NUM_REGS − ZERO_REG.
- WAW ordering between an outstanding port B result and a port A write is the issue logic's responsibility. Any write clears busy.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, write ports and state).
- Write: bypassed in the same cycle; visible from the array from the next cycle.
- Issue: rd_busy and busy_count reflect it from the cycle after iss_en.
- Reset (reset=0, any time, asynchronous):
  - all registers 0, all busy bits 0, busy_count 0
  - rd_data and rd_busy then follow the read rules: data 0 unless bypassed, busy 0
- Writes, issues and reads are all ignored while reset is low. The first edge after deassertion is a normal edge.

## Structure
- Package regfile_pkg holds the clog2-based AW helper, a zero-register index constant, and a struct/typedef for one write port (en, addr, data). The port-A-over-B priority rule lives there as a shared function, reused by forwarding logic elsewhere.
- One sub-module, regfile_scoreboard: busy vector, set/clear logic, busy_count counter and rd_busy lookup. The data array, write priority and bypass stay in regfile_sb.

## Test plan
- Reset with all registers preloaded → all rd_data 0, rd_busy 0, busy_count 0; issue/write with reset low → no effect.
- wa_en, addr 5, 0xDEADBEEF, rd_addr0=5 → same-cycle rd_data0=0xDEADBEEF; next cycle with wa_en=0 → still 0xDEADBEEF.
- wa_en and wb_en both to addr 7, A=0x1111, B=0x2222 → bypass and stored value 0x1111; write to addr 0 → reads 0.
- iss_en addr 3 → next cycle rd_busy=1, busy_count=1; wb_en addr 3 with data 0x42 → same cycle rd_busy=0, rd_data=0x42; next cycle busy_count=0.
- Issue regs 1, 2 → busy_count 2; then in one cycle wa to 1, wb to 2, iss to 4 → busy_count 1. Iss_en and wb_en same addr 6 → bit stays set.
- Issue all registers 1..NUM_REGS−1 (repeat some) → busy_count=NUM_REGS−1 with no overflow. Assert reset mid-sequence → count 0 immediately (asynchronous).
